lcd_pattern_gen: RTL and testbench

Parametrised RGB565 test-pattern generator for the RGB LCD path. It sits between the LCD timing driver, which supplies `pixel_xpos`/`pixel_ypos`, and the pixel output mux. It extends the fixed five-bar colour bar with four selectable modes, a configurable bar count, and a scrolling animation. Mode changes and scroll steps are applied only at frame boundaries so the panel never shows a torn frame.

---
 rtl/lcd_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB565 test-pattern generator for the RGB LCD path.
// Takes pixel coordinates from the LCD timing driver and produces a
// registered pixel colour. Four modes are supported: vertical bars,
// horizontal bars, a checkerboard and scrolling vertical bars. Mode changes
// and scroll steps take effect only at the frame boundary, so a frame is
// never torn.
// Optional feature macro: LCD_PATTERN_BORDER_EN draws a one-pixel red
// border around the active area, overriding every mode.
module lcd_pattern_gen #(
    parameter logic [10:0] H_DISP      = 11'd800,
    parameter logic [10:0] V_DISP      = 11'd480,
    parameter int          BARS        = 8,
    parameter int          CELL_LOG2   = 5,
    parameter logic [10:0] SCROLL_STEP = 11'd4,
    parameter logic [7:0]  SCROLL_DIV  = 8'd2
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [1:0]  mode_sel,
    input  logic        mode_vld,
    output logic [15:0] pixel_data,
    output logic        frame_end
);

    // Bar sizes are fixed at elaboration; the last bar takes the remainder.
    localparam logic [10:0] BAR_W = H_DISP / 11'(BARS);
    localparam logic [10:0] BAR_H = V_DISP / 11'(BARS);

    typedef enum logic [1:0] {
        MODE_VBAR   = 2'd0,
        MODE_HBAR   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_t;

    mode_t       r_mode_pend;
    mode_t       r_mode_act;
    logic [7:0]  r_fc;
    logic [10:0] r_offset;

    logic        w_active;
    logic        w_fb;
    logic        w_enter_scroll;
    logic        w_fc_wrap;
    logic [11:0] w_sum;
    logic [10:0] w_xs;
    logic [11:0] w_off_sum;
    logic [10:0] w_off_next;
    logic [BARS-1:1] w_xge;
    logic [BARS-1:1] w_xsge;
    logic [BARS-1:1] w_yge;
    logic [2:0]  w_xbar;
    logic [2:0]  w_xsbar;
    logic [2:0]  w_ybar;
    logic [15:0] w_colour;

    // Palette index k mod 8 to RGB565 colour.
    function automatic logic [15:0] palette(input logic [2:0] p);
        logic [15:0] c;
        case (p)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'h0000;
            3'd2:    c = 16'hF800;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'h001F;
            3'd5:    c = 16'hFFE0;
            3'd6:    c = 16'h07FF;
            default: c = 16'hF81F;
        endcase
        return c;
    endfunction

    assign w_active = (pixel_xpos < H_DISP) && (pixel_ypos < V_DISP);
    assign w_fb     = (pixel_xpos == H_DISP - 11'd1) && (pixel_ypos == V_DISP - 11'd1);

    // Scrolled column: x + offset folded back once into the active width.
    assign w_sum = {1'b0, pixel_xpos} + {1'b0, r_offset};
    assign w_xs  = (w_sum >= {1'b0, H_DISP}) ? 11'(w_sum - {1'b0, H_DISP}) : w_sum[10:0];

    // Next scroll offset, wrapped modulo the active width.
    assign w_off_sum  = {1'b0, r_offset} + {1'b0, SCROLL_STEP};
    assign w_off_next = (w_off_sum >= {1'b0, H_DISP}) ? 11'(w_off_sum - {1'b0, H_DISP})
                                                      : w_off_sum[10:0];

    assign w_enter_scroll = (r_mode_pend == MODE_SCROLL) && (r_mode_act != MODE_SCROLL);
    assign w_fc_wrap      = (r_fc == SCROLL_DIV - 8'd1);

    // Constant bar boundaries; each comparator says "at or past boundary k".
    for (genvar k = 1; k < BARS; k++) begin : g_bound
        localparam logic [10:0] XB = 11'(k * BAR_W);
        localparam logic [10:0] YB = 11'(k * BAR_H);
        assign w_xge[k]  = (pixel_xpos >= XB);
        assign w_xsge[k] = (w_xs >= XB);
        assign w_yge[k]  = (pixel_ypos >= YB);
    end

    // Bar index (mod 8) is the highest boundary that has been passed.
    always_comb begin
        w_xbar  = 3'd0;
        w_xsbar = 3'd0;
        w_ybar  = 3'd0;
        for (int k = 1; k < BARS; k++) begin
            if (w_xge[k])  w_xbar  = 3'(k);
            if (w_xsge[k]) w_xsbar = 3'(k);
            if (w_yge[k])  w_ybar  = 3'(k);
        end
    end

    // Colour for the current coordinate; blanking is black.
    always_comb begin
        w_colour = 16'h0000;
        if (w_active) begin
            unique case (r_mode_act)
                MODE_VBAR:   w_colour = palette(w_xbar);
                MODE_HBAR:   w_colour = palette(w_ybar);
                MODE_CHECK:  w_colour = (pixel_xpos[CELL_LOG2] ^ pixel_ypos[CELL_LOG2])
                                        ? 16'h0000 : 16'hFFFF;
                MODE_SCROLL: w_colour = palette(w_xsbar);
                default:     w_colour = 16'h0000;
            endcase
`ifdef LCD_PATTERN_BORDER_EN
            if ((pixel_xpos == 11'd0) || (pixel_xpos == H_DISP - 11'd1) ||
                (pixel_ypos == 11'd0) || (pixel_ypos == V_DISP - 11'd1)) begin
                w_colour = 16'hF800;
            end
`endif
        end
    end

    // Pending mode follows the last strobe; active mode swaps only at frame end.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode_pend <= MODE_VBAR;
            r_mode_act  <= MODE_VBAR;
        end else begin
            if (mode_vld) r_mode_pend <= mode_t'(mode_sel);
            if (w_fb)     r_mode_act  <= r_mode_pend;
        end
    end

    // Frame counter and scroll offset advance at frame end in every mode.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fc     <= 8'd0;
            r_offset <= 11'd0;
        end else if (w_fb) begin
            r_fc <= w_fc_wrap ? 8'd0 : r_fc + 8'd1;
            if (w_enter_scroll)  r_offset <= 11'd0;
            else if (w_fc_wrap)  r_offset <= w_off_next;
        end
    end

    // Output register: colour and frame-end marker share one cycle of latency.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pixel_data <= 16'h0000;
            frame_end  <= 1'b0;
        end else begin
            pixel_data <= w_colour;
            frame_end  <= w_fb;
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: self-checking bench for lcd_pattern_gen.
// Two instances share stimulus: default BARS=8 and BARS=3 (remainder case).
// Expected colours come from an arithmetic model of the pattern rules.
module tb_lcd_pattern_gen;

    localparam int H    = 800;
    localparam int V    = 480;
    localparam int STEP = 4;
    localparam int DIV  = 2;

    logic        lcd_clk;
    logic        sys_rst_n;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [1:0]  mode_sel;
    logic        mode_vld;
    logic [15:0] pd8, pd3;
    logic        fe8, fe3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_act, m_pend, m_fc, m_off;
    logic [15:0] pal [8] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0,
                             16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F};

    lcd_pattern_gen u_dut8 (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .mode_sel(mode_sel), .mode_vld(mode_vld),
        .pixel_data(pd8), .frame_end(fe8)
    );

    lcd_pattern_gen #(.BARS(3)) u_dut3 (
        .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .mode_sel(mode_sel), .mode_vld(mode_vld),
        .pixel_data(pd3), .frame_end(fe3)
    );

    // Clock
    initial lcd_clk = 1'b0;
    always #5 lcd_clk = ~lcd_clk;

    function automatic int bar_of(int c, int len, int bars);
        int b;
        b = c / (len / bars);
        if (b > bars - 1) b = bars - 1;
        return b % 8;
    endfunction

    function automatic logic [15:0] model_pix(int x, int y, int bars);
        int xs;
        if (x >= H || y >= V) return 16'h0000;
`ifdef LCD_PATTERN_BORDER_EN
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 16'hF800;
`endif
        case (m_act)
            0: return pal[bar_of(x, H, bars)];
            1: return pal[bar_of(y, V, bars)];
            2: return ((((x >> 5) ^ (y >> 5)) & 1) == 0) ? 16'hFFFF : 16'h0000;
            default: begin
                xs = (x + m_off) % H;
                return pal[bar_of(xs, H, bars)];
            end
        endcase
    endfunction

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_fc = 0; m_off = 0;
    endtask

    // Drive one pixel, clock it, and return what the outputs must now show.
    task automatic cycle(input int x, input int y, input bit vld, input int sel,
                         output logic [15:0] e8, output logic [15:0] e3, output bit efe);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        mode_vld   = vld;
        mode_sel   = 2'(sel);
        e8  = model_pix(x, y, 8);
        e3  = model_pix(x, y, 3);
        efe = (x == H - 1) && (y == V - 1);
        @(posedge lcd_clk);
        #1;
        if (efe) begin
            if (m_pend == 3 && m_act != 3) m_off = 0;
            else if (m_fc == DIV - 1)      m_off = (m_off + STEP) % H;
            m_fc  = (m_fc == DIV - 1) ? 0 : m_fc + 1;
            m_act = m_pend;
        end
        if (vld) m_pend = sel;
        mode_vld = 1'b0;
    endtask

    // Strobe a new mode mid-frame, then close the frame so it becomes active.
    task automatic switch_mode(input int sel);
        logic [15:0] e8, e3;
        bit efe;
        cycle($urandom_range(1, H - 2), $urandom_range(1, V - 2), 1'b1, sel, e8, e3, efe);
        cycle(H - 1, V - 1, 1'b0, 0, e8, e3, efe);
    endtask

    task automatic test_reset();
        logic [15:0] e8, e3;
        bit efe;
        sys_rst_n = 1'b0;
        pixel_xpos = '0; pixel_ypos = '0; mode_sel = '0; mode_vld = 1'b0;
        model_reset();
        repeat (3) @(posedge lcd_clk);
        #1;
        n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL reset_pd got %h exp 0000", pd8); end
        n_checks++; if (fe8 !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b exp 0", fe8); end
        sys_rst_n = 1'b1;
        cycle(5, 5, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL post_reset_pd got %h exp FFFF", pd8); end
    endtask

    task automatic test_vbars();
        logic [15:0] e8, e3;
        bit efe;
        for (int x = 0; x < H; x++) begin
            cycle(x, 100, 1'b0, $urandom_range(0, 3), e8, e3, efe);
            n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL vbar8 x=%0d got %h exp %h", x, pd8, e8); end
            n_checks++; if (pd3 !== e3) begin n_fail++; $display("FAIL vbar3 x=%0d got %h exp %h", x, pd3, e3); end
            n_checks++; if (fe8 !== 1'b0) begin n_fail++; $display("FAIL vbar_fe x=%0d got %b exp 0", x, fe8); end
            if (x == 99)  begin n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL vbar8_99 got %h exp FFFF", pd8); end end
            if (x == 100) begin n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL vbar8_100 got %h exp 0000", pd8); end end
            if (x == 700) begin n_checks++; if (pd8 !== 16'hF81F) begin n_fail++; $display("FAIL vbar8_700 got %h exp F81F", pd8); end end
            if (x == 532) begin n_checks++; if (pd3 !== 16'hF800) begin n_fail++; $display("FAIL vbar3_532 got %h exp F800", pd3); end end
            if (x == 797) begin n_checks++; if (pd3 !== 16'hF800) begin n_fail++; $display("FAIL vbar3_797 got %h exp F800", pd3); end end
            if (x == 799) begin n_checks++; if (pd3 !== 16'hF800) begin n_fail++; $display("FAIL vbar3_799 got %h exp F800", pd3); end end
        end
    endtask

    task automatic test_hbars();
        logic [15:0] e8, e3;
        bit efe;
        int x, y;
        switch_mode(1);
        n_checks++; if (fe8 !== 1'b1) begin n_fail++; $display("FAIL hbar_fe got %b exp 1", fe8); end
        for (int i = 0; i < 60; i++) begin
            x = $urandom_range(0, H - 1);
            y = $urandom_range(0, V - 2);
            cycle(x, y, 1'b0, 0, e8, e3, efe);
            n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL hbar8 y=%0d got %h exp %h", y, pd8, e8); end
            n_checks++; if (pd3 !== e3) begin n_fail++; $display("FAIL hbar3 y=%0d got %h exp %h", y, pd3, e3); end
        end
    endtask

    task automatic test_checker();
        logic [15:0] e8, e3;
        bit efe;
        int x, y;
        switch_mode(2);
        cycle(32, 32, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL chk_32_32 got %h exp FFFF", pd8); end
        cycle(32, 1, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL chk_32_1 got %h exp 0000", pd8); end
        cycle(1, 1, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL chk_1_1 got %h exp FFFF", pd8); end
        // mid-frame request for mode 0 must not disturb this frame
        cycle(400, 200, 1'b1, 0, e8, e3, efe);
        n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL chk_strobe got %h exp %h", pd8, e8); end
        for (int i = 0; i < 30; i++) begin
            x = $urandom_range(0, H - 1);
            y = $urandom_range(0, V - 2);
            cycle(x, y, 1'b0, 0, e8, e3, efe);
            n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL chk_rand (%0d,%0d) got %h exp %h", x, y, pd8, e8); end
        end
        cycle(32, 1, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL chk_hold got %h exp 0000", pd8); end
        cycle(H - 1, V - 1, 1'b0, 0, e8, e3, efe);
        cycle(32, 1, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL chk_after_fb got %h exp FFFF", pd8); end
    endtask

    task automatic test_scroll();
        logic [15:0] e8, e3;
        bit efe;
        bit saw_796;
        int x, y;
        saw_796 = 1'b0;
        switch_mode(3);
        for (int f = 0; f < 402; f++) begin
            y = $urandom_range(1, V - 2);
            cycle(0, y, 1'b0, 0, e8, e3, efe);
            n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL scr_x0 off=%0d got %h exp %h", m_off, pd8, e8); end
            x = $urandom_range(0, H - 1);
            cycle(x, y, 1'b0, 0, e8, e3, efe);
            n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL scr8 x=%0d off=%0d got %h exp %h", x, m_off, pd8, e8); end
            n_checks++; if (pd3 !== e3) begin n_fail++; $display("FAIL scr3 x=%0d off=%0d got %h exp %h", x, m_off, pd3, e3); end
            if (m_off == 796) begin
                saw_796 = 1'b1;
                cycle(3, y, 1'b0, 0, e8, e3, efe);
                n_checks++; if (pd8 !== 16'hF81F) begin n_fail++; $display("FAIL scr_wrap_x3 got %h exp F81F", pd8); end
                cycle(4, y, 1'b0, 0, e8, e3, efe);
                n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL scr_wrap_x4 got %h exp FFFF", pd8); end
            end
            cycle(H - 1, V - 1, 1'b0, 0, e8, e3, efe);
            n_checks++; if (fe8 !== 1'b1) begin n_fail++; $display("FAIL scr_fe got %b exp 1", fe8); end
        end
        n_checks++; if (saw_796 !== 1'b1) begin n_fail++; $display("FAIL scr_reach_796 got %b exp 1", saw_796); end
    endtask

    task automatic test_fb_strobe();
        logic [15:0] e8, e3;
        bit efe;
        int x, y, pulses;
        cycle(H - 1, V - 1, 1'b1, 1, e8, e3, efe);
        n_checks++; if (fe8 !== 1'b1) begin n_fail++; $display("FAIL fbs_fe got %b exp 1", fe8); end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            x = $urandom_range(0, H - 1);
            y = $urandom_range(0, V - 2);
            cycle(x, y, 1'b0, 0, e8, e3, efe);
            if (fe8 === 1'b1) pulses++;
            n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL fbs_old_mode (%0d,%0d) got %h exp %h", x, y, pd8, e8); end
        end
        cycle(H - 1, V - 1, 1'b0, 0, e8, e3, efe);
        if (fe8 === 1'b1) pulses++;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL fbs_pulses got %0d exp 1", pulses); end
        cycle(10, 70, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL fbs_new8 got %h exp 0000", pd8); end
        n_checks++; if (pd3 !== 16'hFFFF) begin n_fail++; $display("FAIL fbs_new3 got %h exp FFFF", pd3); end
    endtask

    task automatic test_blanking();
        logic [15:0] e8, e3;
        bit efe;
        int x, y;
        for (int i = 0; i < 22; i++) begin
            if (i == 0)      begin x = H - 1; y = V; end
            else if (i == 1) begin x = H;     y = V - 1; end
            else if ($urandom_range(0, 1) == 1) begin x = $urandom_range(H, 2047); y = $urandom_range(0, 2047); end
            else begin x = $urandom_range(0, H - 1); y = $urandom_range(V, 2047); end
            cycle(x, y, 1'b0, 0, e8, e3, efe);
            n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL blank_pd (%0d,%0d) got %h exp 0000", x, y, pd8); end
            n_checks++; if (fe8 !== 1'b0) begin n_fail++; $display("FAIL blank_fe (%0d,%0d) got %b exp 0", x, y, fe8); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e8, e3;
        bit efe;
        switch_mode(3);
        cycle(300, 200, 1'b0, 0, e8, e3, efe);
        cycle(H - 1, V - 1, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== e8) begin n_fail++; $display("FAIL rmid_pre_pd got %h exp %h", pd8, e8); end
        n_checks++; if (fe8 !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_fe got %b exp 1", fe8); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL rmid_pd got %h exp 0000", pd8); end
        n_checks++; if (fe8 !== 1'b0) begin n_fail++; $display("FAIL rmid_fe got %b exp 0", fe8); end
        model_reset();
        @(posedge lcd_clk);
        #2;
        sys_rst_n = 1'b1;
        cycle(0, 240, 1'b0, 0, e8, e3, efe);
`ifdef LCD_PATTERN_BORDER_EN
        n_checks++; if (pd8 !== 16'hF800) begin n_fail++; $display("FAIL rmid_0_240 got %h exp F800", pd8); end
`else
        n_checks++; if (pd8 !== 16'hFFFF) begin n_fail++; $display("FAIL rmid_0_240 got %h exp FFFF", pd8); end
`endif
        cycle(150, 240, 1'b0, 0, e8, e3, efe);
        n_checks++; if (pd8 !== 16'h0000) begin n_fail++; $display("FAIL rmid_150 got %h exp 0000", pd8); end
        n_checks++; if (pd3 !== e3) begin n_fail++; $display("FAIL rmid_150_b3 got %h exp %h", pd3, e3); end
    endtask

    initial begin
        test_reset();
        test_vbars();
        test_hbars();
        test_checker();
        test_scroll();
        test_fb_strobe();
        test_blanking();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
